// File: rtl/bp_fe_fetch_queue_wide_if.sv
// rtl/bp_fe_fetch_queue_wide_if.sv - enqueue/dequeue handshake bundle for the wide fetch queue
interface bp_fe_fetch_queue_wide_if #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int fetch_width_p = 2,
    parameter int els_p         = 8,
    parameter int meta_width_p  = 36,
    parameter int msg_width_p   = 3
);
    logic                                   flush_i;
    logic                                   enq_v_i;
    logic                                   enq_ready_o;
    logic [vaddr_width_p-1:0]               enq_pc_i;
    logic [fetch_width_p*instr_width_p-1:0] enq_instr_i;
    logic [fetch_width_p-1:0]               enq_mask_i;
    logic [msg_width_p-1:0]                 enq_msg_i;
    logic [meta_width_p-1:0]                enq_meta_i;
    logic                                   deq_v_o;
    logic                                   deq_ready_and_i;
    logic [vaddr_width_p-1:0]               deq_pc_o;
    logic [instr_width_p-1:0]               deq_instr_o;
    logic [msg_width_p-1:0]                 deq_msg_o;
    logic [meta_width_p-1:0]                deq_meta_o;
    logic [$clog2(els_p+1)-1:0]             count_o;

    modport master (
        output flush_i, enq_v_i, enq_pc_i, enq_instr_i, enq_mask_i, enq_msg_i, enq_meta_i,
               deq_ready_and_i,
        input  enq_ready_o, deq_v_o, deq_pc_o, deq_instr_o, deq_msg_o, deq_meta_o, count_o
    );

    modport slave (
        input  flush_i, enq_v_i, enq_pc_i, enq_instr_i, enq_mask_i, enq_msg_i, enq_meta_i,
               deq_ready_and_i,
        output enq_ready_o, deq_v_o, deq_pc_o, deq_instr_o, deq_msg_o, deq_meta_o, count_o
    );
endinterface

// File: rtl/bp_fe_fetch_queue_wide.sv
// rtl/bp_fe_fetch_queue_wide.sv - multi-lane fetch queue, group enqueue, single-entry dequeue
module bp_fe_fetch_queue_wide #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int fetch_width_p = 2,
    parameter int els_p         = 8,
    parameter int meta_width_p  = 36,
    parameter int msg_width_p   = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_fe_fetch_queue_wide_if.slave  io
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic [msg_width_p-1:0]   msg;
        logic [meta_width_p-1:0]  meta;
    } entry_s;

    entry_s                mem_q [els_p];
    entry_s                mem_d [els_p];
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic [cnt_w_lp-1:0]   n_enq;
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  is_exc;

    // Ready looks only at registered occupancy so it never depends on the consumer.
    assign io.enq_ready_o = ~reset_i
                          & ((cnt_w_lp'(els_p) - count_q) >= cnt_w_lp'(fetch_width_p));
    assign is_exc   = (io.enq_msg_i != '0);
    assign enq_fire = io.enq_v_i & io.enq_ready_o & ~io.flush_i;
    assign io.deq_v_o = (count_q != '0);
    assign deq_fire = io.deq_v_o & io.deq_ready_and_i;

    assign io.deq_pc_o    = mem_q[rptr_q].pc;
    assign io.deq_instr_o = mem_q[rptr_q].instr;
    assign io.deq_msg_o   = mem_q[rptr_q].msg;
    assign io.deq_meta_o  = mem_q[rptr_q].meta;
    assign io.count_o     = count_q;

    always_comb begin
        mem_d = mem_q;
        n_enq = '0;
        if (enq_fire) begin
            if (is_exc) begin
                n_enq                = cnt_w_lp'(1);
                mem_d[wptr_q].pc     = io.enq_pc_i;
                mem_d[wptr_q].instr  = io.enq_instr_i[instr_width_p-1:0];
                mem_d[wptr_q].msg    = io.enq_msg_i;
                mem_d[wptr_q].meta   = io.enq_meta_i;
            end else begin
                // Mask is contiguous from lane 0, so lane i lands at wptr+i.
                for (int i = 0; i < fetch_width_p; i++) begin
                    if (io.enq_mask_i[i]) begin
                        n_enq = n_enq + cnt_w_lp'(1);
                        mem_d[ptr_w_lp'(wptr_q + ptr_w_lp'(i))].pc =
                            io.enq_pc_i + vaddr_width_p'(4 * i);
                        mem_d[ptr_w_lp'(wptr_q + ptr_w_lp'(i))].instr =
                            io.enq_instr_i[i*instr_width_p +: instr_width_p];
                        mem_d[ptr_w_lp'(wptr_q + ptr_w_lp'(i))].msg  = '0;
                        mem_d[ptr_w_lp'(wptr_q + ptr_w_lp'(i))].meta = io.enq_meta_i;
                    end
                end
            end
        end

        wptr_d  = wptr_q + n_enq[ptr_w_lp-1:0];
        rptr_d  = rptr_q + ptr_w_lp'(deq_fire);
        count_d = count_q + n_enq - cnt_w_lp'(deq_fire);

        if (io.flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        count_q <= cnt_w_lp'(els_p));
    a_mask_contig: assert property (@(posedge clk_i) disable iff (reset_i)
        (enq_fire && !is_exc) |->
            ((io.enq_mask_i & (io.enq_mask_i + fetch_width_p'(1))) == '0));
`endif
endmodule

// File: tb/tb_bp_fe_fetch_queue_wide.sv
// tb/tb_bp_fe_fetch_queue_wide.sv - scoreboard bench for the wide fetch queue
module tb_bp_fe_fetch_queue_wide;
    localparam int VW  = 39;
    localparam int IW  = 32;
    localparam int FW  = 2;
    localparam int ELS = 8;
    localparam int MW  = 36;
    localparam int GW  = 3;

    typedef struct packed {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        logic [GW-1:0] msg;
        logic [MW-1:0] meta;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_fe_fetch_queue_wide_if #(
        .vaddr_width_p(VW), .instr_width_p(IW), .fetch_width_p(FW),
        .els_p(ELS), .meta_width_p(MW), .msg_width_p(GW)
    ) io ();

    bp_fe_fetch_queue_wide #(
        .vaddr_width_p(VW), .instr_width_p(IW), .fetch_width_p(FW),
        .els_p(ELS), .meta_width_p(MW), .msg_width_p(GW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (io)
    );

    ent_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   mcount       = 0;

    task automatic set_idle();
        io.flush_i         = 1'b0;
        io.enq_v_i         = 1'b0;
        io.enq_pc_i        = '0;
        io.enq_instr_i     = '0;
        io.enq_mask_i      = '0;
        io.enq_msg_i       = '0;
        io.enq_meta_i      = '0;
        io.deq_ready_and_i = 1'b0;
    endtask

    // One clock: drive at negedge, check against the model, push/pop the scoreboard.
    task automatic cycle(input logic ev, input logic [VW-1:0] pc, input logic [FW*IW-1:0] instr,
                         input logic [FW-1:0] mask, input logic [GW-1:0] msg,
                         input logic [MW-1:0] meta, input logic dr, input logic fl);
        logic mready;
        ent_t e;
        ent_t got;
        io.enq_v_i = ev; io.enq_pc_i = pc; io.enq_instr_i = instr; io.enq_mask_i = mask;
        io.enq_msg_i = msg; io.enq_meta_i = meta; io.deq_ready_and_i = dr; io.flush_i = fl;
        #1;
        mready = ((ELS - mcount) >= FW);
        tests_run++;
        if (io.count_o !== 4'(mcount)) begin
            tests_failed++;
            $display("FAIL count: got %0d expected %0d", io.count_o, mcount);
        end
        tests_run++;
        if (io.enq_ready_o !== mready) begin
            tests_failed++;
            $display("FAIL enq_ready: got %b expected %b (count %0d)", io.enq_ready_o, mready, mcount);
        end
        tests_run++;
        if (io.deq_v_o !== (mcount != 0)) begin
            tests_failed++;
            $display("FAIL deq_v: got %b expected %b", io.deq_v_o, (mcount != 0));
        end
        if (dr && mcount > 0) begin
            tests_run++;
            got = {io.deq_pc_o, io.deq_instr_o, io.deq_msg_o, io.deq_meta_o};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL deq_entry: got pc %h but scoreboard empty", io.deq_pc_o);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL deq_entry: got pc %h instr %h msg %h meta %h expected pc %h instr %h msg %h meta %h",
                             got.pc, got.instr, got.msg, got.meta, e.pc, e.instr, e.msg, e.meta);
                end
            end
            mcount--;
        end
        if (ev && mready && !fl) begin
            if (msg != '0) begin
                sb.push_back({pc, instr[IW-1:0], msg, meta});
                mcount++;
            end else begin
                for (int i = 0; i < FW; i++) begin
                    if (mask[i]) begin
                        sb.push_back({pc + VW'(4 * i), instr[i*IW +: IW], GW'(0), meta});
                        mcount++;
                    end
                end
            end
        end
        if (fl) begin
            sb.delete();
            mcount = 0;
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic enq2(input logic [VW-1:0] pc, input logic [IW-1:0] b, input logic [IW-1:0] a);
        cycle(1'b1, pc, {b, a}, 2'b11, 3'd0, MW'(pc), 1'b0, 1'b0);
    endtask

    task automatic deq1();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        #1;
        tests_run++;
        if (io.enq_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 0", io.enq_ready_o);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        mcount = 0;
        tests_run++;
        if (io.count_o !== 4'd0 || io.deq_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got count %0d deq_v %b expected 0 0", io.count_o, io.deq_v_o);
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (io.enq_ready_o !== 1'b0 || io.count_o !== 4'd0 || io.deq_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL test_reset: got ready %b count %0d deq_v %b expected 0 0 0",
                     io.enq_ready_o, io.count_o, io.deq_v_o);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (io.enq_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL test_reset_release: got ready %b expected 1", io.enq_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        enq2(39'h80000000, 32'hBBBB0002, 32'hAAAA0001);
        tests_run++;
        if (io.count_o !== 4'd2 || io.deq_instr_o !== 32'hAAAA0001 || io.deq_pc_o !== 39'h80000000) begin
            tests_failed++;
            $display("FAIL test_basic_head: got count %0d instr %h pc %h expected 2 aaaa0001 80000000",
                     io.count_o, io.deq_instr_o, io.deq_pc_o);
        end
        deq1();
        tests_run++;
        if (io.deq_instr_o !== 32'hBBBB0002 || io.deq_pc_o !== 39'h80000004) begin
            tests_failed++;
            $display("FAIL test_basic_second: got instr %h pc %h expected bbbb0002 80000004",
                     io.deq_instr_o, io.deq_pc_o);
        end
        deq1();
    endtask

    task automatic test_fill();
        do_reset();
        for (int g = 0; g < 4; g++) enq2(VW'(32'h100 + 8 * g), IW'(2 * g + 1), IW'(2 * g));
        tests_run++;
        if (io.count_o !== 4'd8 || io.enq_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL test_fill_full: got count %0d ready %b expected 8 0", io.count_o, io.enq_ready_o);
        end
        deq1();
        tests_run++;
        if (io.count_o !== 4'd7 || io.enq_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL test_fill_7: got count %0d ready %b expected 7 0", io.count_o, io.enq_ready_o);
        end
        deq1();
        tests_run++;
        if (io.count_o !== 4'd6 || io.enq_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL test_fill_6: got count %0d ready %b expected 6 1", io.count_o, io.enq_ready_o);
        end
        for (int k = 0; k < 6; k++) deq1();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 3; g++) enq2(VW'(32'h400 + 8 * g), IW'(g + 16), IW'(g));
        for (int k = 0; k < 6; k++) deq1();
        enq2(39'h2000, 32'h66, 32'h77);
        enq2(39'h3000, 32'h88, 32'h99);
        for (int k = 0; k < 4; k++) deq1();
        tests_run++;
        if (io.count_o !== 4'd0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL test_wrap_drain: got count %0d left %0d expected 0 0", io.count_o, sb.size());
        end
    endtask

    task automatic test_exception();
        do_reset();
        enq2(39'h500, 32'h11, 32'h10);
        cycle(1'b1, 39'h1000, {32'hDEAD0001, 32'hC0DE0000}, 2'b11, 3'd3, 36'h5A, 1'b0, 1'b0);
        tests_run++;
        if (io.count_o !== 4'd3) begin
            tests_failed++;
            $display("FAIL test_exception_count: got %0d expected 3", io.count_o);
        end
        deq1();
        deq1();
        tests_run++;
        if (io.deq_msg_o !== 3'd3 || io.deq_pc_o !== 39'h1000) begin
            tests_failed++;
            $display("FAIL test_exception_head: got msg %0d pc %h expected 3 1000", io.deq_msg_o, io.deq_pc_o);
        end
        deq1();
    endtask

    task automatic test_flush();
        do_reset();
        enq2(39'h600, 32'h1, 32'h0);
        enq2(39'h608, 32'h3, 32'h2);
        cycle(1'b1, 39'h610, {32'h5, 32'h4}, 2'b01, 3'd0, 36'h0, 1'b0, 1'b0);
        tests_run++;
        if (io.count_o !== 4'd5) begin
            tests_failed++;
            $display("FAIL test_flush_pre: got %0d expected 5", io.count_o);
        end
        cycle(1'b1, 39'h700, {32'h7, 32'h6}, 2'b11, 3'd0, 36'h1, 1'b1, 1'b1);
        tests_run++;
        if (io.count_o !== 4'd0 || io.deq_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL test_flush_post: got count %0d deq_v %b expected 0 0", io.count_o, io.deq_v_o);
        end
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        enq2(39'h900, 32'h21, 32'h20);
        cycle(1'b1, 39'h908, {32'h23, 32'h22}, 2'b01, 3'd0, 36'h2, 1'b0, 1'b0);
        cycle(1'b1, 39'h90C, {32'h25, 32'h24}, 2'b01, 3'd0, 36'h3, 1'b1, 1'b0);
        tests_run++;
        if (io.count_o !== 4'd3) begin
            tests_failed++;
            $display("FAIL test_simul_count: got %0d expected 3", io.count_o);
        end
        cycle(1'b1, 39'h910, {32'h27, 32'h26}, 2'b01, 3'd0, 36'h4, 1'b0, 1'b0);
        tests_run++;
        if (io.count_o !== 4'd4) begin
            tests_failed++;
            $display("FAIL test_partial_count: got %0d expected 4", io.count_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [FW-1:0] m;
        logic [GW-1:0] g;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       m = 2'b00;
                1:       m = 2'b01;
                default: m = 2'b11;
            endcase
            g = ($urandom_range(0, 7) == 0) ? GW'($urandom_range(1, 7)) : GW'(0);
            cycle(1'($urandom_range(0, 1)), VW'({$urandom, $urandom}), {$urandom, $urandom}, m, g,
                  MW'({$urandom, $urandom}), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0));
        end
        for (int k = 0; k < ELS + 2; k++) deq1();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_exception();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
